// File: rtl/maths_op_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : maths_op_sched_if
// Description : Request/response bundle for the shared maths-unit scheduler.
// Revision    : 1.0
// ============================================================================
interface maths_op_sched_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [1:0]  req0_op;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req0_cin;

    logic        req1_valid;
    logic        req1_ready;
    logic [1:0]  req1_op;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req1_cin;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_lo;
    logic [15:0] rsp_hi;
    logic        rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_cin,
        output req1_valid, req1_op, req1_a, req1_b, req1_cin,
        input  req0_ready, req1_ready,
        output rsp_ready,
        input  rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_op, req1_a, req1_b, req1_cin,
        output req0_ready, req1_ready,
        input  rsp_ready,
        output rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/maths_op_sched.sv
`default_nettype none
// ============================================================================
// Module      : maths_op_sched
// Description : Round-robin scheduler sharing one 16-bit add/mul/div datapath
//               between two requesters, with a multicycle hold per operation.
// Revision    : 1.0
// ============================================================================
module maths_op_sched #(
    parameter int ADD_CYCLES = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    maths_op_sched_if.slave    bus
);

    localparam int c_MAX_CYC = (ADD_CYCLES > MUL_CYCLES)
                             ? ((ADD_CYCLES > DIV_CYCLES) ? ADD_CYCLES : DIV_CYCLES)
                             : ((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES);
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

    localparam logic [c_CNT_W-1:0] c_ADD_LD = c_CNT_W'(ADD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_MUL_LD = c_CNT_W'(MUL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LD = c_CNT_W'(DIV_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_MUL = 2'b01;
    localparam logic [1:0] c_OP_DIV = 2'b10;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_EXEC = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_last;
    logic [1:0]         r_op;
    logic [15:0]        r_a;
    logic [15:0]        r_b;
    logic               r_cin;
    logic               r_id;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [15:0]        r_rsp_lo;
    logic [15:0]        r_rsp_hi;
    logic               r_rsp_err;

    logic               w_grant_vld;
    logic               w_grant;
    logic               w_accept;
    logic               w_req0_ready;
    logic               w_req1_ready;
    logic [1:0]         w_sel_op;
    logic [15:0]        w_sel_a;
    logic [15:0]        w_sel_b;
    logic               w_sel_cin;
    logic [c_CNT_W-1:0] w_ld_cnt;
    logic [16:0]        w_sum;
    logic [31:0]        w_prod;
    logic [15:0]        w_div_den;
    logic [15:0]        w_quot;
    logic [15:0]        w_rem;
    logic [15:0]        w_res_lo;
    logic [15:0]        w_res_hi;
    logic               w_res_err;

    // On contention the requester that was not served last wins.
    always_comb begin
        w_grant_vld = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = ~r_last;
        end else begin
            w_grant = bus.req1_valid;
        end
    end

    assign w_accept  = (r_state == c_S_IDLE) && w_grant_vld;
    assign w_sel_op  = w_grant ? bus.req1_op  : bus.req0_op;
    assign w_sel_a   = w_grant ? bus.req1_a   : bus.req0_a;
    assign w_sel_b   = w_grant ? bus.req1_b   : bus.req0_b;
    assign w_sel_cin = w_grant ? bus.req1_cin : bus.req0_cin;

    always_comb begin
        case (w_sel_op)
            c_OP_ADD: w_ld_cnt = c_ADD_LD;
            c_OP_MUL: w_ld_cnt = c_MUL_LD;
            c_OP_DIV: w_ld_cnt = c_DIV_LD;
            default:  w_ld_cnt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: if (w_grant_vld)        w_next_state = c_S_EXEC;
            c_S_EXEC: if (r_cnt == '0)        w_next_state = c_S_RESP;
            c_S_RESP: if (bus.rsp_ready)      w_next_state = c_S_IDLE;
            default:                          w_next_state = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        if (r_state == c_S_IDLE && w_grant_vld) begin
            w_req0_ready = ~w_grant;
            w_req1_ready = w_grant;
        end
    end

    // Units read only the latched operands, so they are stable for the whole hold window.
    assign w_sum     = {1'b0, r_a} + {1'b0, r_b} + {16'd0, r_cin};
    assign w_prod    = {16'd0, r_a} * {16'd0, r_b};
    assign w_div_den = (r_b == 16'd0) ? 16'd1 : r_b;
    assign w_quot    = r_a / w_div_den;
    assign w_rem     = r_a % w_div_den;

    always_comb begin
        w_res_lo  = 16'd0;
        w_res_hi  = 16'd0;
        w_res_err = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_res_lo = w_sum[15:0];
                w_res_hi = {15'd0, w_sum[16]};
            end
            c_OP_MUL: begin
                w_res_lo = w_prod[15:0];
                w_res_hi = w_prod[31:16];
            end
            c_OP_DIV: begin
                if (r_b == 16'd0) begin
                    w_res_lo  = 16'hFFFF;
                    w_res_hi  = r_a;
                    w_res_err = 1'b1;
                end else begin
                    w_res_lo = w_quot;
                    w_res_hi = w_rem;
                end
            end
            default: w_res_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_op        <= 2'b00;
            r_a         <= 16'd0;
            r_b         <= 16'd0;
            r_cin       <= 1'b0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_lo    <= 16'd0;
            r_rsp_hi    <= 16'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op   <= w_sel_op;
                r_a    <= w_sel_a;
                r_b    <= w_sel_b;
                r_cin  <= w_sel_cin;
                r_id   <= w_grant;
                r_last <= w_grant;
                r_cnt  <= w_ld_cnt;
            end
            if (r_state == c_S_EXEC) begin
                if (r_cnt == '0) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    r_rsp_lo    <= w_res_lo;
                    r_rsp_hi    <= w_res_hi;
                    r_rsp_err   <= w_res_err;
                end else begin
                    r_cnt <= r_cnt - c_ONE;
                end
            end
            if (r_state == c_S_RESP && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.req0_ready = w_req0_ready;
    assign bus.req1_ready = w_req1_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_lo     = r_rsp_lo;
    assign bus.rsp_hi     = r_rsp_hi;
    assign bus.rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_maths_op_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_maths_op_sched
// Description : Scoreboard bench for maths_op_sched with directed vectors.
// Revision    : 1.0
// ============================================================================
module tb_maths_op_sched;

    typedef struct {
        logic        id;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        err;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    int   acc_cyc;
    logic prev_valid;
    exp_t sb[$];

    maths_op_sched_if bus ();

    maths_op_sched #(
        .ADD_CYCLES (1),
        .MUL_CYCLES (2),
        .DIV_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency on rising rsp_valid, contents on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (bus.req0_ready || bus.req1_ready) begin
            acc_cyc = cyc + 1;
            chk("one_ready", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
        end
        if (bus.rsp_valid && !prev_valid) begin
            if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
            else                chk("latency", 32'(cyc - acc_cyc), 32'(sb[0].lat));
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_hs", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id",  {31'd0, bus.rsp_id},  {31'd0, e.id});
                chk("rsp_lo",  {16'd0, bus.rsp_lo},  {16'd0, e.lo});
                chk("rsp_hi",  {16'd0, bus.rsp_hi},  {16'd0, e.hi});
                chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
            end
        end
        prev_valid = bus.rsp_valid;
    end

    task automatic drive(input logic id, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic cin);
        if (id == 1'b0) begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
            bus.req0_valid = 1'b1;
        end else begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
            bus.req1_valid = 1'b1;
        end
    endtask

    task automatic issue(input logic id, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic cin, input logic [15:0] elo,
                         input logic [15:0] ehi, input logic eerr, input int lat);
        logic rdy;
        rdy = 1'b0;
        drive(id, op, a, b, cin);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            rdy = id ? bus.req1_ready : bus.req0_ready;
            if (rdy) break;
        end
        if (!rdy) begin
            chk("accept_timeout", 32'd1, 32'd0);
        end else begin
            sb.push_back('{id: id, lo: elo, hi: ehi, err: eerr, lat: lat});
            @(posedge clk);
            @(negedge clk);
            // Still valid, but the op is in flight: ready must stay low.
            rdy = id ? bus.req1_ready : bus.req0_ready;
            chk("ready_one_cycle", {31'd0, rdy}, 32'd0);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic g0, g1, exp_g, rdy;
        int   n0, n1;
        n_cmp = 0; n_fail = 0; acc_cyc = 0; prev_valid = 1'b0;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_lohi",  {bus.rsp_hi, bus.rsp_lo}, 32'd0);
        chk("reset_iderr", {30'd0, bus.rsp_id, bus.rsp_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed single operations
        issue(1'b0, 2'b00, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 16'h0001, 1'b0, 1); drain();
        issue(1'b1, 2'b01, 16'h1234, 16'h0100, 1'b0, 16'h3400, 16'h0012, 1'b0, 2); drain();
        issue(1'b0, 2'b10, 16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0, 4); drain();
        issue(1'b0, 2'b10, 16'd5,    16'd0,    1'b0, 16'hFFFF, 16'd5,    1'b1, 4); drain();
        issue(1'b1, 2'b11, 16'h55AA, 16'h1234, 1'b1, 16'h0000, 16'h0000, 1'b1, 1); drain();

        // Contention: last served was req1, so grants go 0,1,0,1...
        n0 = 0; n1 = 0; exp_g = 1'b0;
        drive(1'b0, 2'b00, 16'h1000, 16'd0, 1'b0);
        drive(1'b1, 2'b00, 16'hF000, 16'h1000, 1'b1);
        for (int k = 0; k < 400 && (n0 < 6 || n1 < 6); k++) begin
            @(negedge clk);
            g0 = bus.req0_ready; g1 = bus.req1_ready;
            if (g0 || g1) begin
                chk("grant_order", {31'd0, g1}, {31'd0, exp_g});
                exp_g = ~exp_g;
            end
            if (g0) sb.push_back('{id: 1'b0, lo: 16'(16'h1000 + 3 * n0), hi: 16'd0, err: 1'b0, lat: 1});
            if (g1) sb.push_back('{id: 1'b1, lo: 16'(n1 + 1), hi: 16'd1, err: 1'b0, lat: 1});
            @(posedge clk); #1;
            if (g0) begin
                n0++;
                if (n0 < 6) drive(1'b0, 2'b00, 16'(16'h1000 + n0), 16'(2 * n0), 1'b0);
                else        bus.req0_valid = 1'b0;
            end
            if (g1) begin
                n1++;
                if (n1 < 6) drive(1'b1, 2'b00, 16'(16'hF000 + n1), 16'h1000, 1'b1);
                else        bus.req1_valid = 1'b0;
            end
        end
        if (n0 < 6 || n1 < 6) chk("contention_timeout", 32'd1, 32'd0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        drain();

        // Backpressure: response held while req1 waits
        bus.rsp_ready = 1'b0;
        issue(1'b0, 2'b01, 16'd3, 16'd5, 1'b0, 16'd15, 16'd0, 1'b0, 2);
        drive(1'b1, 2'b00, 16'd7, 16'd8, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (bus.rsp_valid) break;
            @(negedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_data",  {bus.rsp_hi, bus.rsp_lo}, 32'h0000_000F);
            chk("bp_iderr", {30'd0, bus.rsp_id, bus.rsp_err}, 32'd0);
            chk("bp_no_accept", {31'd0, bus.req1_ready}, 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_cycle_ready", {31'd0, bus.req1_ready}, 32'd0);
        @(negedge clk);
        rdy = bus.req1_ready;
        chk("bp_accept_after_hs", {31'd0, rdy}, 32'd1);
        if (rdy) sb.push_back('{id: 1'b1, lo: 16'd15, hi: 16'd0, err: 1'b0, lat: 1});
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        drain();

        // Reset in the middle of a DIV
        issue(1'b0, 2'b10, 16'd200, 16'd3, 1'b0, 16'd66, 16'd2, 1'b0, 4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_lohi",  {bus.rsp_hi, bus.rsp_lo}, 32'd0);
        chk("rst_iderr", {30'd0, bus.rsp_id, bus.rsp_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 2'b00, 16'd1,  16'd2,  1'b0);
        drive(1'b1, 2'b00, 16'd10, 16'd20, 1'b0);
        @(negedge clk);
        chk("post_rst_grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
        if (bus.req0_ready) sb.push_back('{id: 1'b0, lo: 16'd3, hi: 16'd0, err: 1'b0, lat: 1});
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        rdy = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            rdy = bus.req1_ready;
            if (rdy) break;
        end
        chk("post_rst_req1", {31'd0, rdy}, 32'd1);
        if (rdy) sb.push_back('{id: 1'b1, lo: 16'd30, hi: 16'd0, err: 1'b0, lat: 1});
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/maths_op_sched.md
Name: maths_op_sched

Overview:
- Shares one set of 16-bit maths units (adder, multiplier, divider/modulo) between two requesters.
- Arbitrates round-robin and latches operands.
- Holds each operation for a parameterised multicycle window so the combinational units can be timed as multicycle paths.
- Returns one registered result per accepted request over a valid/ready response channel.

Parameters:
- ADD_CYCLES, 1, cycles from accept to rsp_valid for ADD (legal range ≥1).
- MUL_CYCLES, 2, cycles from accept to rsp_valid for MUL (legal range ≥1).
- DIV_CYCLES, 4, cycles from accept to rsp_valid for DIV (legal range ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  2  00 ADD, 01 MUL, 10 DIV, 11 reserved.
- req0_a  in  16  operand A.
- req0_b  in  16  operand B.
- req0_cin  in  1  carry-in, used by ADD only.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester index of the result.
- rsp_lo  out  16  primary result.
- rsp_hi  out  16  secondary result.
- rsp_err  out  1  divide-by-zero or reserved op.

Behaviour:
- Reset: one clock and an asynchronous, active-low reset (rst_n). Assertion immediately forces state IDLE and clears rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_err, the cycle counter and the latched operands. The round-robin pointer is set so req0 has priority on the first contention. Reset mid-operation discards the operation; no response is produced.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant is computed combinationally.
  - One valid requester wins.
  - Both valid: the requester not served last wins.
  - reqN_ready = (state==IDLE) && grant==N. Ready is never high outside IDLE and never for both requesters.
  - Accept edge: latch op, a, b, cin and id; load counter with OPCYC-1, where OPCYC is the op's cycle count (reserved op uses 1); update pointer to the winner; go to EXEC.
  - Neither requester valid: stay in IDLE.
- EXEC:
  - Counter decrements each cycle.
  - When counter==0: register the result into rsp_* and set rsp_valid. This edge is exactly OPCYC edges after the accept edge. Go to RESP.
  - Request inputs are ignored; changes on them never affect the in-flight op.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: clear rsp_valid and go to IDLE.
  - Next accept is no earlier than the following edge, so the throughput bound is one op per OPCYC+2 cycles with rsp_ready tied high.
- Result rules (all arithmetic unsigned):
  - ADD: {hi[0],lo} = a+b+cin (17-bit); hi[15:1]=0; err=0.
  - MUL: {hi,lo} = full 32-bit product a*b; err=0.
  - DIV, b≠0: lo=a/b, hi=a%b, err=0.
  - DIV, b==0: lo=16'hFFFF, hi=a, err=1.
  - Reserved op (11): lo=0, hi=0, err=1.
- Fairness: a continuously valid requester is served within one other operation.
- rsp_valid is never deasserted without rsp_ready, except by reset.

Test Plan:
- Single ADD on req0: a=16'hFFFF, b=16'h0001, cin=1, rsp_ready=1. Expect req0_ready high one cycle; rsp_valid exactly 1 edge after accept; lo=16'h0001, hi=16'h0001, id=0, err=0.
- MUL on req1: a=16'h1234, b=16'h0100, default params. Expect rsp_valid 2 edges after accept; lo=16'h3400, hi=16'h0012, id=1.
- DIV: a=100, b=7, then a=5, b=0. Expect lo=14, hi=2, err=0, rsp_valid 4 edges after accept; then lo=16'hFFFF, hi=5, err=1.
- Contention: both requesters valid continuously, 6 ADDs each. Expect grants 0,1,0,1…; never both ready in the same cycle; all 12 responses returned with correct id.
- Backpressure: rsp_ready held low 10 cycles after a MUL completes. Expect rsp_* stable throughout, no new accept, and the pending req1 accepted only after the handshake.
- Reset mid-DIV: deassert rst_n during EXEC. Expect rsp_valid=0 and all outputs 0 immediately; no response after release; first post-reset contention goes to req0.
